// File: rtl/result_capture.sv
// result_capture: stores adder results LATENCY cycles after each start pulse and serves them through a four-phase readback port
module result_capture #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              fp_in,
  input  logic                     clr,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, ACK = 2'd2, WAIT = 2'd3;
  logic [LATENCY-1:0] vld;
  logic [AW-1:0]      wptr, waddr, raddr;
  logic [AW:0]        cnt_nx;
  logic [1:0]         state;
  logic [31:0]        mem [DEPTH];
  logic               cap, we;
  assign cap    = vld[LATENCY-1];
  // clear wins over a simultaneous capture, so that word lands at address 0
  assign we     = cap & (clr | ~full);
  assign waddr  = clr ? '0 : wptr;
  assign cnt_nx = (clr ? {(AW+1){1'b0}} : count) + (AW+1)'(we);
  assign rd_ack = state == ACK;
  always_ff @(posedge clk)
    if (!rst) begin
      vld      <= '0;
      wptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vld      <= (vld << 1) | LATENCY'(start);
      wptr     <= waddr + AW'(we);
      count    <= cnt_nx;
      full     <= cnt_nx == (AW+1)'(DEPTH);
      overflow <= ~clr & (overflow | (cap & full));
    end
  always_ff @(posedge clk)
    if (rst && we) mem[waddr] <= fp_in;
  always_ff @(posedge clk)
    if (!rst) begin
      state   <= IDLE;
      raddr   <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: if (rd_req) begin
          raddr <= rd_addr;
          state <= READ;
        end
        READ: begin
          rd_data <= ({1'b0, raddr} < count) ? mem[raddr] : '0;
          state   <= ACK;
        end
        ACK:     state <= WAIT;
        default: if (!rd_req) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_result_capture.sv
// tb_result_capture: random and directed stimulus checked against a queue/array model of the capture store
module tb_result_capture;
  localparam int L  = 4;
  localparam int D  = 16;
  localparam int AW = 4;
  logic          clk = 0, rst = 0, start = 0, clr = 0, rd_req = 0;
  logic [31:0]   fp_in = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic          rd_ack, full, overflow;
  logic [AW:0]   count;
  int n_checks = 0, n_err = 0, edge_n = 0, m_cnt = 0;
  int q[$];
  bit m_ovf = 0, chk_en = 0;
  logic [31:0] m_mem [D];

  result_capture #(.LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .fp_in(fp_in), .clr(clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: each start becomes a capture due exactly L edges later; words fill addresses 0..D-1 in order
  always @(posedge clk) begin : model
    bit cap;
    edge_n++;
    if (!rst) begin
      q.delete();
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      cap = q.size() > 0 && q[0] == edge_n;
      if (cap) void'(q.pop_front());
      if (start) q.push_back(edge_n + L);
      if (clr) begin
        m_cnt = 0;
        m_ovf = 0;
      end
      if (cap) begin
        if (m_cnt == D) m_ovf = 1;
        else begin
          m_mem[m_cnt] = fp_in;
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == D));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_captures(input int n, input logic [31:0] base);
    for (int i = 0; i < n + L; i++) begin
      start = i < n;
      fp_in = (i >= L) ? base + 32'(i - L) : $urandom();
      tick();
    end
    start = 0;
  endtask

  task automatic do_read(input int a, input logic [31:0] exp, input int hold, input string name);
    int k;
    rd_addr = AW'(a);
    rd_req  = 1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!rd_ack && k < 10);
    if (!rd_ack) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
    else begin
      chk(name, rd_data, exp);
      repeat (hold + 1) begin
        tick();
        chk({name, "_ack_once"}, 32'(rd_ack), 32'd0);
        chk({name, "_hold"}, rd_data, exp);
      end
    end
    rd_req = 0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] w [4];
    w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1;
    chk_en = 1;
    repeat (3) tick();
    // single capture exactly L edges after start
    start = 1;
    fp_in = $urandom();
    tick();
    start = 0;
    repeat (L - 1) begin
      fp_in = $urandom();
      tick();
    end
    fp_in = 32'h40400000;
    tick();
    fp_in = $urandom();
    chk("single_count", 32'(count), 32'd1);
    chk("single_model", 32'(m_cnt), 32'd1);
    do_read(0, 32'h40400000, 0, "single_read");
    // back-to-back starts
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < L + 4; i++) begin
      start = i < 4;
      fp_in = (i >= L) ? w[i-L] : $urandom();
      tick();
    end
    start = 0;
    chk("b2b_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) do_read(i, w[i], 0, "b2b_read");
    // fill to full, then one more to overflow
    clr = 1;
    tick();
    clr = 0;
    run_captures(16, 32'h1000);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd0);
    chk("fill_count", 32'(count), 32'd16);
    run_captures(1, 32'h2000);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    do_read(15, 32'h100F, 0, "ovf_read15");
    do_read(0, 32'h1000, 0, "ovf_read0");
    // clear on the same edge as a capture
    start = 1;
    tick();
    start = 0;
    repeat (L - 1) tick();
    clr = 1;
    fp_in = 32'hC0000000;
    tick();
    clr = 0;
    chk("clrcap_count", 32'(count), 32'd1);
    chk("clrcap_overflow", 32'(overflow), 32'd0);
    chk("clrcap_full", 32'(full), 32'd0);
    do_read(0, 32'hC0000000, 0, "clrcap_read");
    // reset two edges after start discards the in-flight result
    clr = 1;
    tick();
    clr = 0;
    start = 1;
    tick();
    start = 0;
    tick();
    rst = 0;
    tick();
    rst = 1;
    repeat (L + 2) tick();
    chk("rstflight_count", 32'(count), 32'd0);
    // read beyond count returns zero, held request gives one ack only
    run_captures(3, 32'h3000);
    do_read(5, 32'h0, 4, "beyond_read");
    do_read(2, 32'h3002, 0, "in_range_read");
    // random traffic
    repeat (400) begin
      start = $urandom_range(0, 2) != 0;
      clr   = $urandom_range(0, 49) == 0;
      rst   = $urandom_range(0, 99) != 0;
      fp_in = $urandom();
      tick();
    end
    start = 0;
    clr   = 0;
    rst   = 1;
    repeat (L + 2) tick();
    for (int a = 0; a < D; a++) do_read(a, (a < m_cnt) ? m_mem[a] : 32'h0, 0, "rand_read");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving the cycles from a start pulse to a valid adder result.
REQ-002 SHALL have parameter DEPTH, default 16, giving the number of result words stored; power of two.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle operand-issue pulse, the same pulse that advances the operand memory.
REQ-006 SHALL have port fp_in, input, 32: adder pipeline result.
REQ-007 SHALL have port clr, input, 1: synchronous clear of write pointer, count and overflow.
REQ-008 SHALL have port rd_req, input, 1: readback request, four-phase handshake.
REQ-009 SHALL have port rd_addr, input, log2(DEPTH): readback address.
REQ-010 SHALL have port rd_data, output, 32: readback word.
REQ-011 SHALL have port rd_ack, output, 1: readback acknowledge.
REQ-012 SHALL have port count, output, log2(DEPTH)+1: number of words stored.
REQ-013 SHALL have port full, output, 1: high when count == DEPTH.
REQ-014 SHALL have port overflow, output, 1: sticky flag set when a capture is dropped because the store is full.

Function
REQ-015 SHALL delay start through a LATENCY-stage valid shift register; start sampled at edge t causes fp_in to be captured at edge t+LATENCY.
REQ-016 SHALL handle back-to-back start pulses (one per cycle) and capture each result in order.
REQ-017 SHALL write each captured word at the write pointer, then increment the pointer and count by 1.
REQ-018 SHALL, when full is high at a capture edge, drop the word, leave the pointer and count unchanged, and set overflow.
REQ-019 SHALL, on clr high, zero the pointer, count and overflow at that edge; memory contents are not cleared; valid pipeline entries in flight are kept.
REQ-020 SHALL, if clr and a capture fall on the same edge, give clr priority: the word goes to address 0, count becomes 1, overflow becomes 0.
REQ-021 SHALL use a readback FSM with states IDLE, READ, ACK, WAIT.
REQ-022 SHALL, in IDLE with rd_req high, register rd_addr and move to READ.
REQ-023 SHALL, in READ, load rd_data from memory and move to ACK; if the registered address >= count, rd_data SHALL be 0x00000000.
REQ-024 SHALL, in ACK, drive rd_ack high for exactly one cycle with rd_data stable, then move to WAIT.
REQ-025 SHALL, in WAIT, hold rd_data and return to IDLE once rd_req is low.
REQ-026 SHALL make a read in READ of an address being written at the same edge return the old contents (read-before-write).
REQ-027 SHALL leave the capture path unaffected by the readback FSM state; capture and readback run concurrently.
REQ-028 SHALL drive full and count from registers; neither is combinational from start.

Reset
REQ-029 SHALL, with rst low at an edge, clear the valid shift register (discarding in-flight results), pointer, count, overflow, full, rd_ack and rd_data (to 0), and force the FSM to IDLE.
REQ-030 SHALL leave memory contents undefined after reset; readback of addresses >= count returns 0 per REQ-023.
REQ-031 SHALL, with rst low mid-handshake, drop rd_ack that edge and ignore rd_req until the first edge with rst high.

Verification
REQ-032 SHALL pass: start at cycle 10 with fp_in = 0x40400000 at cycle 14 -> word captured at edge 14, count = 1; readback of address 0 -> rd_data = 0x40400000 with a one-cycle rd_ack.
REQ-033 SHALL pass: 4 consecutive start pulses with results 0x3F800000, 0x40000000, 0x40400000, 0x40800000 -> count = 4 and addresses 0-3 hold those words in order.
REQ-034 SHALL pass: 17 captures with DEPTH = 16 -> full = 1 after the 16th, overflow = 1 after the 17th, count = 16, address 15 holds the 16th word.
REQ-035 SHALL pass: clr on the same edge as a capture of 0xC0000000 -> count = 1, overflow = 0, address 0 = 0xC0000000.
REQ-036 SHALL pass: rst low for 1 cycle, 2 cycles after a start pulse -> no capture occurs and count stays 0.
REQ-037 SHALL pass: readback of address 5 with count = 3 -> rd_data = 0x00000000 with rd_ack asserted; holding rd_req high keeps the FSM in WAIT with no second ack.
